// File: rtl/ice_uart_pkg.sv
// ice_uart_pkg
// Shared definitions for the ICE UART blocks.
//   tx_state_e : transmitter FSM states
//   PAR_*      : parity mode encodings for the PARITY parameter
//   clog2      : ceiling log2 for sizing counters and pointers
package ice_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ice_sync_fifo.sv
// ice_sync_fifo
// Single-clock FIFO with first-word fall-through read: pop_data always
// shows the head entry, and pop consumes it on the next rising edge.
//   clk, reset  : clock, synchronous active-high reset (flushes the FIFO)
//   push        : write push_data (ignored while full)
//   pop         : drop the head entry (ignored while empty)
//   full, empty : status, derived from the registered count
//   count       : entries held, 0..DEPTH
module ice_sync_fifo
    import ice_uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ice_uart_tx.sv
// ice_uart_tx
// Buffered 8-bit UART transmitter, LSB first, optional parity.
//   clk, reset  : clock, synchronous active-high reset (aborts frame, flushes queue)
//   tx_data     : byte to send, qualified by tx_valid
//   tx_valid    : push request
//   tx_ready    : queue has room this cycle
//   uart_txd    : serial line, idle high, registered
//   busy        : frame in progress or queue non-empty
//   fifo_count  : bytes waiting in the queue
//   overflow    : sticky, a push was attempted while the queue was full
module ice_uart_tx
    import ice_uart_pkg::*;
#(
    parameter int BAUD_DIV   = 174,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       uart_txd,
    output logic                       busy,
    output logic [clog2(FIFO_DEPTH):0] fifo_count,
    output logic                       overflow
);

    localparam int BW = clog2(BAUD_DIV);

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [7:0]    head_data;
    logic          baud_last;

    ice_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign baud_last = (baud_q == BW'(BAUD_DIV - 1));

    // Pop from idle, or at the last cycle of a stop bit so the next
    // start bit follows with no gap.
    assign fifo_pop = ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_last))
                      && !fifo_empty;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        txd_d     = txd_q;

        if (state_q != ST_IDLE) begin
            baud_d = baud_last ? '0 : baud_q + BW'(1);
        end

        // txd_d is the line value for the bit that starts next cycle.
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    if (bit_idx_q == 3'd7) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // A pop overrides the above: load the head byte and begin a start bit.
        if (fifo_pop) begin
            state_d   = ST_START;
            baud_d    = '0;
            bit_idx_d = 3'd0;
            shift_d   = head_data;
            par_d     = (PARITY == PAR_ODD) ? ~^head_data : ^head_data;
            txd_d     = 1'b0;
        end
    end

    assign ovf_d = ovf_q | (tx_valid & fifo_full);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_ready = !fifo_full;
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ice_uart_tx.sv
// tb_ice_uart_tx
// Three transmitters (no parity, even, odd) share one stimulus stream.
// Each is checked every cycle against a waveform-level reference: a queue
// of accepted bytes and, for the frame on the wire, the expected bit
// pattern indexed by elapsed cycles / BAUD_DIV.
module tb_ice_uart_tx;

    localparam int B = 4;
    localparam int D = 16;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;

    logic       ready_w [N];
    logic       txd_w   [N];
    logic       busy_w  [N];
    logic       ovf_w   [N];
    logic [4:0] cnt_w   [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        ice_uart_tx #(
            .BAUD_DIV   (B),
            .FIFO_DEPTH (D),
            .PARITY     (gi)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .tx_data    (tx_data),
            .tx_valid   (tx_valid),
            .tx_ready   (ready_w[gi]),
            .uart_txd   (txd_w[gi]),
            .busy       (busy_w[gi]),
            .fifo_count (cnt_w[gi]),
            .overflow   (ovf_w[gi])
        );
    end

    // Reference state per instance.
    logic [7:0]  mbuf   [N][32];
    int          mhead  [N];
    int          msize  [N];
    int          mpos   [N];
    bit          mact   [N];
    bit          movf   [N];
    logic [10:0] mframe [N];

    int checks   = 0;
    int failures = 0;

    function automatic logic [10:0] make_frame(input int p, input logic [7:0] d);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (p == 0)      f[9] = 1'b1;
        else if (p == 1) f[9] = ^d;
        else             f[9] = ~^d;
        f[10]  = 1'b1;
        return f;
    endfunction

    // Advance the reference by one rising edge using the inputs seen there.
    task automatic model_edge(input int k);
        int flen;
        bit full;
        bit do_push;
        flen = ((k == 0) ? 10 : 11) * B;
        if (reset) begin
            mhead[k] = 0;
            msize[k] = 0;
            mpos[k]  = 0;
            mact[k]  = 1'b0;
            movf[k]  = 1'b0;
            return;
        end
        full    = (msize[k] == D);
        do_push = tx_valid && !full;
        if (tx_valid && full) movf[k] = 1'b1;
        if (mact[k]) begin
            mpos[k] = mpos[k] + 1;
            if (mpos[k] == flen) mact[k] = 1'b0;
        end
        if (!mact[k] && msize[k] > 0) begin
            mframe[k] = make_frame(k, mbuf[k][mhead[k]]);
            mhead[k]  = (mhead[k] + 1) % 32;
            msize[k]  = msize[k] - 1;
            mpos[k]   = 0;
            mact[k]   = 1'b1;
        end
        if (do_push) begin
            mbuf[k][(mhead[k] + msize[k]) % 32] = tx_data;
            msize[k] = msize[k] + 1;
        end
    endtask

    task automatic check_outputs();
        logic       exp_line;
        logic [4:0] exp_cnt;
        logic       exp_rdy;
        logic       exp_busy;
        logic       exp_ovf;
        for (int k = 0; k < N; k++) begin
            exp_line = mact[k] ? mframe[k][mpos[k] / B] : 1'b1;
            exp_cnt  = 5'(msize[k]);
            exp_rdy  = (msize[k] < D);
            exp_busy = mact[k] || (msize[k] != 0);
            exp_ovf  = movf[k];
            checks++;
            assert (txd_w[k] === exp_line) else begin
                failures++;
                $error("FAIL line[%0d] got=%b exp=%b t=%0t", k, txd_w[k], exp_line, $time);
            end
            checks++;
            assert (cnt_w[k] === exp_cnt) else begin
                failures++;
                $error("FAIL count[%0d] got=%0d exp=%0d t=%0t", k, cnt_w[k], exp_cnt, $time);
            end
            checks++;
            assert (ready_w[k] === exp_rdy) else begin
                failures++;
                $error("FAIL ready[%0d] got=%b exp=%b t=%0t", k, ready_w[k], exp_rdy, $time);
            end
            checks++;
            assert (busy_w[k] === exp_busy) else begin
                failures++;
                $error("FAIL busy[%0d] got=%b exp=%b t=%0t", k, busy_w[k], exp_busy, $time);
            end
            checks++;
            assert (ovf_w[k] === exp_ovf) else begin
                failures++;
                $error("FAIL overflow[%0d] got=%b exp=%b t=%0t", k, ovf_w[k], exp_ovf, $time);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < N; k++) model_edge(k);
        #1;
        check_outputs();
    endtask

    task automatic push(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        $display("push data=0x%02h t=%0t", d, $time);
        tick();
        tx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        for (int k = 0; k < N; k++) begin
            mhead[k] = 0; msize[k] = 0; mpos[k] = 0;
            mact[k]  = 1'b0; movf[k] = 1'b0; mframe[k] = '1;
        end
        idle(3);
        for (int k = 0; k < N; k++) begin
            chk("reset_txd",   32'(txd_w[k]),   32'd1);
            chk("reset_ready", 32'(ready_w[k]), 32'd1);
            chk("reset_busy",  32'(busy_w[k]),  32'd0);
            chk("reset_count", 32'(cnt_w[k]),   32'd0);
        end
        reset = 1'b0;
        idle(2);

        // Single byte at idle: start bit appears on the edge after the push.
        push(8'h55);
        tick();
        chk("first_start_bit", 32'(txd_w[0]), 32'd0);
        idle(45);
        chk("idle_after_frame", 32'(busy_w[0]), 32'd0);

        // Two back-to-back bytes.
        tx_valid = 1'b1; tx_data = 8'hA3;
        $display("push data=0x%02h t=%0t", tx_data, $time);
        tick();
        tx_data = 8'h0F;
        $display("push data=0x%02h t=%0t", tx_data, $time);
        tick();
        tx_valid = 1'b0;
        idle(100);

        // Fill past capacity while the line is busy.
        push(8'($urandom));
        for (int i = 0; i < 17; i++) push(8'($urandom));
        for (int k = 0; k < N; k++) begin
            chk("overflow_set", 32'(ovf_w[k]),   32'd1);
            chk("full_ready",   32'(ready_w[k]), 32'd0);
        end
        idle(17 * 11 * B + 20);
        for (int k = 0; k < N; k++) chk("overflow_sticky", 32'(ovf_w[k]), 32'd1);

        // Reset during data bit 3 with five bytes queued.
        for (int i = 0; i < 6; i++) push(8'($urandom));
        idle(13);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("abort_txd",   32'(txd_w[k]), 32'd1);
            chk("abort_count", 32'(cnt_w[k]), 32'd0);
            chk("abort_busy",  32'(busy_w[k]), 32'd0);
            chk("abort_ovf",   32'(ovf_w[k]), 32'd0);
        end
        idle(60);

        // Push on the edge where the no-parity frame's stop bit ends.
        push(8'($urandom));
        idle(10 * B);
        push(8'($urandom));
        idle(100);

        // Sparse random traffic.
        for (int i = 0; i < 400; i++) begin
            tx_valid = ($urandom_range(0, 31) == 0);
            tx_data  = 8'($urandom);
            if (tx_valid) $display("push data=0x%02h t=%0t", tx_data, $time);
            tick();
        end
        tx_valid = 1'b0;
        idle(D * 11 * B + 60);
        for (int k = 0; k < N; k++) chk("drained_busy", 32'(busy_w[k]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
